vend_ctrl_multi: RTL

//  Parametrised vending controller, successor to the single-product seller FSM.
//  - Accepts NUM_COIN coin denominations and serves NUM_PROD products, each with its own price.
//  - Supports customer cancel with full refund.
//  - Vend and change/refund outputs are registered.
//  - Sits between the coin-acceptor/keypad front end and the dispenser driver.

---
 rtl/vend_pkg.sv | 32 +++
 rtl/vend_coin_decode.sv | 25 ++
 rtl/vend_ctrl_multi.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types, default tables and configuration helpers for the multi-product vending controller.
package vend_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PAY  = 1'b1
  } state_e;

  // Coin values and prices are counted in half-units. Entry i sits in bits [8*i +: 8].
  localparam int unsigned        DEF_NUM_COIN = 3;
  localparam logic [3*8-1:0]     DEF_COIN_VAL = {8'd4, 8'd2, 8'd1};
  localparam int unsigned        DEF_NUM_PROD = 2;
  localparam logic [2*8-1:0]     DEF_PRICE    = {8'd5, 8'd3};

  // Returns the largest 8-bit entry among the first n entries of a packed table.
  function automatic int unsigned tbl_max(input logic [255:0] tbl, input int unsigned n);
    int unsigned m;
    m = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n && 32'(tbl[i*8 +: 8]) > m) m = 32'(tbl[i*8 +: 8]);
    end
    return m;
  endfunction

  // The worst-case credit is (price - 1) plus the largest coin. It must fit in w bits.
  function automatic bit cred_w_ok(input int unsigned max_price,
                                   input int unsigned max_coin,
                                   input int unsigned w);
    return (w >= 32) || (((max_price + max_coin - 1) >> w) == 0);
  endfunction

endpackage

// File: rtl/vend_coin_decode.sv
// Combinational coin decoder. It turns the coin strobe vector into a legal flag, the coin value
// and an error flag for patterns that have more than one bit set.
module vend_coin_decode
  import vend_pkg::*;
#(
  parameter int unsigned                NUM_COIN = DEF_NUM_COIN,
  parameter logic [NUM_COIN*8-1:0]      COIN_VAL = DEF_COIN_VAL,
  parameter int unsigned                CRED_W   = 4
) (
  input  logic [NUM_COIN-1:0] coin_i,
  output logic                legal_o,
  output logic [CRED_W-1:0]   value_o,
  output logic                err_o
);

  always_comb begin
    legal_o = $onehot(coin_i);
    err_o   = (coin_i != '0) && !legal_o;
    value_o = '0;
    for (int unsigned i = 0; i < NUM_COIN; i++) begin
      if (legal_o && coin_i[i]) value_o = CRED_W'(COIN_VAL[i*8 +: 8]);
    end
  end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-coin, multi-product vending controller with cancel/refund and registered output pulses.
// The optional idle auto-refund is built when the macro VEND_TIMEOUT_EN is defined.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int unsigned            NUM_COIN = DEF_NUM_COIN,
  parameter logic [NUM_COIN*8-1:0]  COIN_VAL = DEF_COIN_VAL,
  parameter int unsigned            NUM_PROD = DEF_NUM_PROD,
  parameter logic [NUM_PROD*8-1:0]  PRICE    = DEF_PRICE,
  parameter int unsigned            SEL_W    = 1,
  parameter int unsigned            CRED_W   = 4,
  parameter int unsigned            TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COIN-1:0] coin,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  output logic                out1,
  output logic [SEL_W-1:0]    out_prod,
  output logic [CRED_W-1:0]   out2,
  output logic                out_refund,
  output logic                busy,
  output logic                coin_err
);

  localparam int unsigned MAX_PRICE = tbl_max(256'(PRICE), NUM_PROD);
  localparam int unsigned MAX_COIN  = tbl_max(256'(COIN_VAL), NUM_COIN);

  if (!cred_w_ok(MAX_PRICE, MAX_COIN, CRED_W) || TIMEOUT == 0 ||
      NUM_PROD > (1 << SEL_W)) begin : g_bad_cfg
    $error("vend_ctrl_multi: CRED_W, SEL_W or TIMEOUT too small for the tables");
  end

  state_e              state_q, state_d;
  logic [CRED_W-1:0]   credit_q, credit_d;
  logic [SEL_W-1:0]    prod_q, prod_d;
  logic                out1_q, out1_d;
  logic [SEL_W-1:0]    out_prod_q, out_prod_d;
  logic [CRED_W-1:0]   out2_q, out2_d;
  logic                refund_q, refund_d;
  logic                err_q;

  logic                coin_legal, coin_bad;
  logic [CRED_W-1:0]   coin_value;
  logic [SEL_W-1:0]    sel_eff, prod_cur;
  logic [CRED_W-1:0]   price_cur, new_credit;
  logic                timeout_hit;

  function automatic logic [CRED_W-1:0] price_of(input logic [SEL_W-1:0] p);
    price_of = '0;
    for (int unsigned j = 0; j < NUM_PROD; j++) begin
      if (p == SEL_W'(j)) price_of = CRED_W'(PRICE[j*8 +: 8]);
    end
  endfunction

  vend_coin_decode #(
    .NUM_COIN (NUM_COIN),
    .COIN_VAL (COIN_VAL),
    .CRED_W   (CRED_W)
  ) u_decode (
    .coin_i   (coin),
    .legal_o  (coin_legal),
    .value_o  (coin_value),
    .err_o    (coin_bad)
  );

  // Out-of-range selections fall back to product 0. The product is locked once payment starts.
  assign sel_eff    = (32'(sel) < NUM_PROD) ? sel : '0;
  assign prod_cur   = (state_q == IDLE) ? sel_eff : prod_q;
  assign price_cur  = price_of(prod_cur);
  assign new_credit = credit_q + coin_value;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no path infers a latch.
    state_d    = state_q;
    credit_d   = credit_q;
    prod_d     = prod_q;
    out1_d     = 1'b0;
    out_prod_d = '0;
    out2_d     = '0;
    refund_d   = 1'b0;

    if (state_q == PAY && (cancel || timeout_hit)) begin
      refund_d = 1'b1;
      out2_d   = new_credit;
      credit_d = '0;
      state_d  = IDLE;
    end else if (coin_legal) begin
      prod_d = prod_cur;
      if (new_credit >= price_cur) begin
        out1_d     = 1'b1;
        out_prod_d = prod_cur;
        out2_d     = new_credit - price_cur;
        credit_d   = '0;
        state_d    = IDLE;
      end else begin
        credit_d = new_credit;
        state_d  = PAY;
      end
    end
  end

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             activity;

  // An illegal coin pattern still counts as customer activity and restarts the idle count.
  assign activity    = (coin != '0) || cancel;
  assign timeout_hit = (state_q == PAY) && !activity && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == PAY && state_d == PAY && !activity) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      prod_q     <= '0;
      out1_q     <= 1'b0;
      out_prod_q <= '0;
      out2_q     <= '0;
      refund_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      prod_q     <= prod_d;
      out1_q     <= out1_d;
      out_prod_q <= out_prod_d;
      out2_q     <= out2_d;
      refund_q   <= refund_d;
      err_q      <= coin_bad;
    end
  end

  assign out1       = out1_q;
  assign out_prod   = out_prod_q;
  assign out2       = out2_q;
  assign out_refund = refund_q;
  assign busy       = (state_q == PAY);
  assign coin_err   = err_q;

endmodule
